// File: rtl/lfsr_decrypt_engine.sv
// LFSR stream-cipher decryptor: recovers tap/seed from the all-space preamble,
// decrypts a 64-byte block from data memory and writes the space-stripped plaintext back.
module lfsr_decrypt_engine #(
  parameter int unsigned MSG_BASE = 64,
  parameter int unsigned OUT_BASE = 0,
  parameter int unsigned OUT_LEN  = 41
) (
  input  logic       CLK,
  input  logic       start,
  output logic [7:0] mem_addr,
  output logic       mem_wr_en,
  output logic [7:0] mem_wdata,
  input  logic [7:0] mem_rdata,
  output logic       done,
  output logic       err,
  output logic [2:0] tap_idx
);

  localparam int unsigned CNT_W  = $clog2(OUT_LEN + 1);
  localparam int unsigned IDX_W  = 6;
  localparam logic [7:0]  SPACE  = 8'h20;
  localparam logic [7:0]  TAPS [8] = '{8'he1, 8'hd4, 8'hc6, 8'hb8, 8'hb4, 8'hb2, 8'hfa, 8'hf3};

  typedef enum logic [2:0] {
    S_LOAD, S_SEARCH, S_DEC_RD, S_DEC_WR, S_PAD, S_DONE
  } state_t;

  state_t             state;
  logic               phase;
  logic [2:0]         ld_idx;
  logic [7:0]         kbuf [8];
  logic [2:0]         pidx;
  logic [7:0]         lfsr;
  logic [IDX_W-1:0]   i_cnt;
  logic [CNT_W-1:0]   wcnt;
  logic               strip;

  logic               match;
  logic [7:0]         plain;
  logic               keep;
  logic               dec_wr;
  logic [CNT_W-1:0]   wcnt_inc;
  logic [CNT_W-1:0]   wcnt_next;

  function automatic logic [7:0] lfsr_step(input logic [7:0] s, input logic [7:0] tap);
    return {s[6:0], ^(s & tap)};
  endfunction

  // Candidate tap must reproduce the whole recovered keystream prefix
  always_comb begin
    match = 1'b1;
    for (int j = 0; j < 7; j++) begin
      if (lfsr_step(kbuf[j], TAPS[pidx]) != kbuf[j+1]) match = 1'b0;
    end
  end

  assign plain     = mem_rdata ^ lfsr;
  assign keep      = !(strip && (plain == SPACE));
  assign dec_wr    = (state == S_DEC_WR) && keep && (wcnt < CNT_W'(OUT_LEN));
  assign wcnt_inc  = wcnt + CNT_W'(1);
  assign wcnt_next = dec_wr ? wcnt_inc : wcnt;

  // Write data comes straight from the read port in DEC_WR, so the strobe is combinational
  assign mem_wr_en = !start && (dec_wr || (state == S_PAD));
  assign mem_wdata = !mem_wr_en ? 8'h00 : ((state == S_PAD) ? SPACE : plain);

  always_ff @(posedge CLK) begin
    if (start) begin
      state    <= S_LOAD;
      phase    <= 1'b0;
      ld_idx   <= '0;
      for (int j = 0; j < 8; j++) kbuf[j] <= '0;
      pidx     <= '0;
      lfsr     <= '0;
      i_cnt    <= '0;
      wcnt     <= '0;
      strip    <= 1'b1;
      done     <= 1'b0;
      err      <= 1'b0;
      tap_idx  <= '0;
      mem_addr <= 8'(MSG_BASE);
    end else begin
      case (state)
        S_LOAD: begin
          if (!phase) begin
            phase <= 1'b1;
          end else begin
            kbuf[ld_idx] <= mem_rdata ^ SPACE;
            phase        <= 1'b0;
            mem_addr     <= mem_addr + 8'd1;
            ld_idx       <= ld_idx + 3'd1;
            if (ld_idx == 3'd7) state <= S_SEARCH;
          end
        end
        S_SEARCH: begin
          if (kbuf[0] == 8'h00) begin
            err   <= 1'b1;
            done  <= 1'b1;
            state <= S_DONE;
          end else if (match) begin
            tap_idx  <= pidx;
            lfsr     <= kbuf[0];
            mem_addr <= 8'(MSG_BASE);
            state    <= S_DEC_RD;
          end else if (pidx == 3'd7) begin
            err   <= 1'b1;
            done  <= 1'b1;
            state <= S_DONE;
          end else begin
            pidx <= pidx + 3'd1;
          end
        end
        S_DEC_RD: begin
          mem_addr <= 8'(OUT_BASE) + 8'(wcnt);
          state    <= S_DEC_WR;
        end
        S_DEC_WR: begin
          lfsr <= lfsr_step(lfsr, TAPS[tap_idx]);
          if (keep) strip <= 1'b0;
          wcnt <= wcnt_next;
          if (wcnt_next == CNT_W'(OUT_LEN)) begin
            done  <= 1'b1;
            state <= S_DONE;
          end else if (i_cnt == IDX_W'(63)) begin
            mem_addr <= 8'(OUT_BASE) + 8'(wcnt_next);
            state    <= S_PAD;
          end else begin
            i_cnt    <= i_cnt + IDX_W'(1);
            mem_addr <= 8'(MSG_BASE) + 8'(i_cnt) + 8'd1;
            state    <= S_DEC_RD;
          end
        end
        S_PAD: begin
          wcnt     <= wcnt_inc;
          mem_addr <= mem_addr + 8'd1;
          if (wcnt_inc == CNT_W'(OUT_LEN)) begin
            done  <= 1'b1;
            state <= S_DONE;
          end
        end
        S_DONE: begin
          done <= 1'b1;
        end
        default: state <= S_DONE;
      endcase
    end
  end

endmodule

// File: tb/tb_lfsr_decrypt_engine.sv
// Bench for lfsr_decrypt_engine: encrypts known messages into a memory model and
// scoreboards every plaintext write against the expected stripped/padded output.
module tb_lfsr_decrypt_engine;

  logic       CLK = 1'b0;
  logic       start = 1'b1;
  logic [7:0] mem_addr;
  logic       mem_wr_en;
  logic [7:0] mem_wdata;
  logic [7:0] mem_rdata = 8'h00;
  logic       done;
  logic       err;
  logic [2:0] tap_idx;

  logic [7:0] mem [256];
  logic [7:0] taps [8] = '{8'he1, 8'hd4, 8'hc6, 8'hb8, 8'hb4, 8'hb2, 8'hfa, 8'hf3};

  typedef struct {
    logic [7:0] addr;
    logic [7:0] data;
  } wr_t;

  wr_t        sb [$];
  logic [7:0] exp_out [41];
  int         n_vec  = 0;
  int         n_miss = 0;
  int         wr_cnt = 0;

  always #5 CLK = ~CLK;

  lfsr_decrypt_engine dut (
    .CLK       (CLK),
    .start     (start),
    .mem_addr  (mem_addr),
    .mem_wr_en (mem_wr_en),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .done      (done),
    .err       (err),
    .tap_idx   (tap_idx)
  );

  // Synchronous memory: read data valid the cycle after the address
  always @(posedge CLK) begin
    if (mem_wr_en === 1'b1) mem[mem_addr] <= mem_wdata;
    mem_rdata <= mem[mem_addr];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_vec++;
    if (obs !== expv) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic logic [7:0] stepf(input logic [7:0] s, input logic [7:0] t);
    return {s[6:0], ^(s & t)};
  endfunction

  always @(negedge CLK) begin
    if (mem_wr_en === 1'b1) begin
      wr_t e;
      wr_cnt++;
      if (sb.size() == 0) begin
        chk("unexpected_wr_queue", 32'(sb.size()), 32'd1);
      end else begin
        e = sb.pop_front();
        chk($sformatf("wr_addr@%0d", e.addr), 32'(mem_addr), 32'(e.addr));
        chk($sformatf("wr_data@%0d", e.addr), 32'(mem_wdata), 32'(e.data));
      end
    end
  end

  task automatic push_exp();
    wr_t e;
    sb.delete();
    for (int j = 0; j < 41; j++) begin
      e.addr = 8'(j);
      e.data = exp_out[j];
      sb.push_back(e);
    end
  endtask

  task automatic run_case(input string name, input int tidx, input logic [7:0] init,
                          input int pre, input string txt, input int corrupt,
                          input bit zero_k0, input bit exp_err, input int abort_at);
    logic [7:0] msg [64];
    logic [7:0] st;
    int         k;
    bit         strip;
    int         cyc;
    int         abort_left;
    int         wr_before;

    for (int j = 0; j < 64; j++) msg[j] = 8'h20;
    for (int j = 0; j < txt.len(); j++) msg[pre + j] = txt[j];
    st = init;
    for (int j = 0; j < 64; j++) begin
      mem[64 + j] = msg[j] ^ st;
      st = stepf(st, taps[tidx]);
    end
    if (corrupt >= 0) mem[corrupt] = mem[corrupt] ^ 8'h55;
    if (zero_k0) mem[64] = 8'h20;
    for (int j = 0; j < 41; j++) mem[j] = 8'ha5;

    k = 0;
    strip = 1'b1;
    for (int j = 0; j < 64; j++) begin
      if (!(strip && msg[j] == 8'h20)) begin
        strip = 1'b0;
        if (k < 41) begin
          exp_out[k] = msg[j];
          k++;
        end
      end
    end
    while (k < 41) begin
      exp_out[k] = 8'h20;
      k++;
    end

    sb.delete();
    if (!exp_err) push_exp();
    wr_cnt = 0;

    @(negedge CLK);
    start = 1'b1;
    @(negedge CLK);
    @(negedge CLK);
    chk({name, ":rst_done"}, 32'(done), 32'd0);
    chk({name, ":rst_err"}, 32'(err), 32'd0);
    chk({name, ":rst_tap"}, 32'(tap_idx), 32'd0);
    chk({name, ":rst_addr"}, 32'(mem_addr), 32'd64);
    chk({name, ":rst_wr"}, 32'(mem_wr_en), 32'd0);
    start = 1'b0;

    cyc = 0;
    abort_left = abort_at;
    while (done !== 1'b1 && cyc < 300) begin
      @(negedge CLK);
      cyc++;
      if (abort_left > 0 && cyc == abort_left) begin
        start = 1'b1;
        @(negedge CLK);
        chk({name, ":abort_done"}, 32'(done), 32'd0);
        chk({name, ":abort_wr"}, 32'(mem_wr_en), 32'd0);
        chk({name, ":abort_addr"}, 32'(mem_addr), 32'd64);
        if (!exp_err) push_exp();
        wr_cnt = 0;
        start = 1'b0;
        cyc = 0;
        abort_left = 0;
      end
    end

    chk({name, ":done"}, 32'(done), 32'd1);
    chk({name, ":latency_le_193"}, 32'(cyc <= 193), 32'd1);
    chk({name, ":err"}, 32'(err), 32'(exp_err));
    if (!exp_err) chk({name, ":tap_idx"}, 32'(tap_idx), 32'(tidx));
    chk({name, ":sb_left"}, 32'(sb.size()), 32'd0);
    if (exp_err) chk({name, ":no_writes"}, 32'(wr_cnt), 32'd0);
    for (int j = 0; j < 41; j++)
      chk($sformatf("%s:mem[%0d]", name, j), 32'(mem[j]), exp_err ? 32'h a5 : 32'(exp_out[j]));

    wr_before = wr_cnt;
    repeat (3) @(negedge CLK);
    chk({name, ":done_held"}, 32'(done), 32'd1);
    chk({name, ":idle_no_wr"}, 32'(wr_cnt), 32'(wr_before));
  endtask

  initial begin
    string knowledge;
    string watson;
    string strip_txt;
    string spaces41;

    knowledge = "Knowledge comes, but wisdom lingers.     ";
    watson    = "Mr. Watson, come here. I want to see you.";
    strip_txt = "";
    for (int j = 0; j < 27; j++) strip_txt = {strip_txt, " "};
    strip_txt = {strip_txt, "Ajok"};
    for (int j = 0; j < 10; j++) strip_txt = {strip_txt, " "};
    spaces41 = "";
    for (int j = 0; j < 41; j++) spaces41 = {spaces41, " "};

    run_case("basic", 4, 8'h6a, 9, knowledge, -1, 1'b0, 1'b0, 0);
    run_case("strip", 6, 8'h2f, 10, strip_txt, -1, 1'b0, 1'b0, 0);
    for (int t = 0; t < 8; t++)
      run_case($sformatf("sweep%0d", t), t, 8'h01, 9, watson, -1, 1'b0, 1'b0, 0);
    run_case("err_corrupt", 4, 8'h6a, 9, knowledge, 68, 1'b0, 1'b1, 0);
    run_case("err_k0", 4, 8'h6a, 9, knowledge, -1, 1'b1, 1'b1, 0);
    run_case("abort", 4, 8'h6a, 9, knowledge, -1, 1'b0, 1'b0, 17 + 4 + 60);
    run_case("spaces", 2, 8'hff, 9, spaces41, -1, 1'b0, 1'b0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
